// File: rtl/multicycle_control_fsm.sv
// Sequenced control unit for the 16-bit multi-cycle CPU: IF/ID/EX/MEM/WB/HALT with memory stalls.
// Optional CTRL_PERF_CNT_EN macro adds num_inst/num_cycle performance counters.
module multicycle_control_fsm #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4,
  parameter int FUNC_SIZE = 6,
  parameter int ALUOP_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 pvs_write_en,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 carry,
  output logic                 halted,
  output logic [2:0]           state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]          num_inst,
  output logic [31:0]          num_cycle
`endif
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ARS = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_ALS = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_NOT = 4'b1100;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b1101;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b1110;

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [OP_SIZE-1:0]   op;
  logic [FUNC_SIZE-1:0] func;
  logic                 is_rtype;
  logic                 is_hlt;
  logic                 is_adi;
  logic                 is_lwd;
  logic                 is_swd;
  logic                 is_jmp;
  logic                 is_illegal;
  logic [ALUOP_W-1:0]   r_alu_op;
  logic                 r_carry;

  assign op   = inst[WORD_SIZE-1 -: OP_SIZE];
  assign func = inst[FUNC_SIZE-1:0];

  always_comb begin
    is_rtype   = (op == 4'd15) && (func < 6'd8);
    is_hlt     = (op == 4'd15) && (func == 6'd29);
    is_adi     = (op == 4'd4);
    is_lwd     = (op == 4'd7);
    is_swd     = (op == 4'd8);
    is_jmp     = (op == 4'd9);
    is_illegal = !(is_rtype || is_hlt || is_adi || is_lwd || is_swd || is_jmp);
  end

  // R-type func order: ADD, SUB, AND, OR, NOT, TCP, ALS, ARS; TCP is NOT with carry-in.
  always_comb begin
    r_alu_op = ALU_ADD;
    r_carry  = 1'b0;
    case (func[2:0])
      3'd0: r_alu_op = ALU_ADD;
      3'd1: r_alu_op = ALU_SUB;
      3'd2: r_alu_op = ALU_AND;
      3'd3: r_alu_op = ALU_OR;
      3'd4: r_alu_op = ALU_NOT;
      3'd5: begin
        r_alu_op = ALU_NOT;
        r_carry  = 1'b1;
      end
      3'd6: r_alu_op = ALU_ALS;
      default: r_alu_op = ALU_ARS;
    endcase
  end

  // Outputs are forced idle while reset_n is low so no strobe leaks during reset.
  always_comb begin
    state_next   = state_reg;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    pvs_write_en = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    alu_op       = ALU_ADD;
    carry        = 1'b0;
    halted       = 1'b0;
    if (reset_n) begin
      case (state_reg)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pvs_write_en = 1'b1;
            state_next   = S_ID;
          end
        end
        S_ID: begin
          if (is_jmp) begin
            pvs_write_en = 1'b1;
            state_next   = S_IF;
          end else if (is_hlt) begin
            state_next = S_HALT;
          end else if (is_illegal) begin
            state_next = S_IF;
          end else begin
            state_next = S_EX;
          end
        end
        S_EX: begin
          alu_src_a = 2'd1;
          if (is_rtype) begin
            alu_src_b = 2'd0;
            alu_op    = r_alu_op;
            carry     = r_carry;
          end else begin
            alu_src_b = 2'd2;
          end
          state_next = (is_lwd || is_swd) ? S_MEM : S_WB;
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lwd;
          mem_write = is_swd;
          // Keep the effective address on the ALU for the whole stalled access.
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          if (mem_ready) begin
            state_next = is_lwd ? S_WB : S_IF;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          state_next = S_IF;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_next = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

`ifdef CTRL_PERF_CNT_EN
  logic inst_done;

  assign inst_done = (state_next == S_IF) &&
                     ((state_reg == S_ID) || (state_reg == S_MEM) || (state_reg == S_WB));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_inst  <= 16'd0;
      num_cycle <= 32'd0;
    end else begin
      if (state_reg != S_HALT) begin
        num_cycle <= num_cycle + 32'd1;
      end
      if (inst_done) begin
        num_inst <= num_inst + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction state/strobe sequences, stalls, halt and reset.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        reset_n;
  logic [15:0] inst;
  logic        mem_ready;
  logic        ir_write, mem_read, mem_write, i_or_d, pvs_write_en, reg_write, halted;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [3:0]  alu_op;
  logic        carry;
  logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] num_inst;
  logic [31:0] num_cycle;
`endif

  int checks = 0;
  int failures = 0;

  // {ir_write, mem_read, mem_write, i_or_d, pvs_write_en, reg_write, halted}
  logic [6:0] strb;
  // {alu_src_a, alu_src_b, alu_op, carry}
  logic [8:0] alu_v;
  assign strb  = {ir_write, mem_read, mem_write, i_or_d, pvs_write_en, reg_write, halted};
  assign alu_v = {alu_src_a, alu_src_b, alu_op, carry};

  multicycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .pvs_write_en(pvs_write_en), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .carry(carry), .halted(halted), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .num_inst(num_inst), .num_cycle(num_cycle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; inst = 16'h0000;
    step(); step(); #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (strb !== 7'b0) begin failures++; $display("FAIL reset_strb got=%b exp=0000000", strb); end
    checks++; if (alu_v !== 9'b0) begin failures++; $display("FAIL reset_alu got=%b exp=000000000", alu_v); end
    reset_n = 1'b1; mem_ready = 1'b0; #1;
    checks++; if (strb !== 7'b0100000) begin failures++; $display("FAIL if_stall_strb got=%b exp=0100000", strb); end
    mem_ready = 1'b1; #1;
    checks++; if (strb !== 7'b1100100) begin failures++; $display("FAIL if_ready_strb got=%b exp=1100100", strb); end
    checks++; if (alu_v !== {2'd0, 2'd1, 4'b0000, 1'b0}) begin failures++; $display("FAIL if_alu got=%b exp=000100000", alu_v); end
    $display("test_reset done");
  endtask

  task automatic test_add();
    inst = 16'hF1C0; #1;
    step();
    checks++; if (state !== 3'd1 || strb !== 7'b0) begin failures++; $display("FAIL add_id got state=%0d strb=%b exp 1/0000000", state, strb); end
    step();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL add_ex_state got=%0d exp=2", state); end
    checks++; if (alu_v !== {2'd1, 2'd0, 4'b0000, 1'b0}) begin failures++; $display("FAIL add_ex_alu got=%b exp=010000000", alu_v); end
    checks++; if (strb !== 7'b0) begin failures++; $display("FAIL add_ex_strb got=%b exp=0000000", strb); end
    step();
    checks++; if (state !== 3'd4 || strb !== 7'b0000010) begin failures++; $display("FAIL add_wb got state=%0d strb=%b exp 4/0000010", state, strb); end
    step();
    checks++; if (state !== 3'd0 || strb !== 7'b1100100) begin failures++; $display("FAIL add_back_if got state=%0d strb=%b exp 0/1100100", state, strb); end
    $display("test_add done");
  endtask

  task automatic test_func_sweep();
    logic [3:0] exp_op [8];
    logic [7:0] exp_c;
    exp_op[0] = 4'b0000; exp_op[1] = 4'b0001; exp_op[2] = 4'b1101; exp_op[3] = 4'b1110;
    exp_op[4] = 4'b1100; exp_op[5] = 4'b1100; exp_op[6] = 4'b0101; exp_op[7] = 4'b0100;
    exp_c = 8'b0010_0000;
    for (int f = 0; f < 8; f++) begin
      inst = 16'hF240 | 16'(f); #1;
      step(); step();
      checks++;
      if (alu_op !== exp_op[f] || carry !== exp_c[f]) begin
        failures++;
        $display("FAIL func%0d_alu got op=%b c=%b exp op=%b c=%b", f, alu_op, carry, exp_op[f], exp_c[f]);
      end
      step(); step();
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL func%0d_return got=%0d exp=0", f, state); end
    end
    $display("test_func_sweep done");
  endtask

  task automatic test_adi_illegal();
    inst = 16'h4105; #1;
    step(); step();
    checks++; if (state !== 3'd2 || alu_v !== {2'd1, 2'd2, 4'b0000, 1'b0}) begin failures++; $display("FAIL adi_ex got state=%0d alu=%b exp 2/011000000", state, alu_v); end
    step();
    checks++; if (state !== 3'd4 || strb !== 7'b0000010) begin failures++; $display("FAIL adi_wb got state=%0d strb=%b exp 4/0000010", state, strb); end
    step();
    inst = 16'h1000; #1;
    step(); step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL illegal_op_nop got=%0d exp=0", state); end
    inst = 16'hF01E; #1;
    step(); step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL illegal_func_nop got=%0d exp=0", state); end
    $display("test_adi_illegal done");
  endtask

  task automatic test_lwd_stall();
    inst = 16'h7123; #1;
    step();
    mem_ready = 1'b0; #1;
    checks++; if (state !== 3'd1 || strb !== 7'b0) begin failures++; $display("FAIL lwd_id got state=%0d strb=%b exp 1/0000000", state, strb); end
    step();
    checks++; if (state !== 3'd2 || alu_v !== {2'd1, 2'd2, 4'b0000, 1'b0}) begin failures++; $display("FAIL lwd_ex got state=%0d alu=%b exp 2/011000000", state, alu_v); end
    step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (state !== 3'd3 || strb !== 7'b0101000) begin failures++; $display("FAIL lwd_mem_wait%0d got state=%0d strb=%b exp 3/0101000", k, state, strb); end
      step();
    end
    mem_ready = 1'b1; #1;
    checks++; if (state !== 3'd3 || strb !== 7'b0101000) begin failures++; $display("FAIL lwd_mem_done got state=%0d strb=%b exp 3/0101000", state, strb); end
    step();
    checks++; if (state !== 3'd4 || strb !== 7'b0000010) begin failures++; $display("FAIL lwd_wb got state=%0d strb=%b exp 4/0000010", state, strb); end
    step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL lwd_back_if got=%0d exp=0", state); end
    $display("test_lwd_stall done");
  endtask

  task automatic test_jmp();
    inst = 16'h9005; #1;
    checks++; if (strb !== 7'b1100100) begin failures++; $display("FAIL jmp_if got=%b exp=1100100", strb); end
    step();
    checks++; if (state !== 3'd1 || strb !== 7'b0000100) begin failures++; $display("FAIL jmp_id got state=%0d strb=%b exp 1/0000100", state, strb); end
    step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL jmp_back_if got=%0d exp=0", state); end
    $display("test_jmp done");
  endtask

  task automatic test_hlt();
    int bad;
    inst = 16'hF01D; #1;
    step(); step();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0]; #1;
      if (state !== 3'd5 || strb !== 7'b0000001) bad++;
      step();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hlt_hold got bad_cycles=%0d exp=0 (last state=%0d strb=%b)", bad, state, strb); end
    reset_n = 1'b0; mem_ready = 1'b1; #1;
    checks++; if (strb !== 7'b0) begin failures++; $display("FAIL hlt_reset_cycle got=%b exp=0000000", strb); end
    step();
    reset_n = 1'b1; #1;
    checks++; if (state !== 3'd0 || halted !== 1'b0) begin failures++; $display("FAIL hlt_after_reset got state=%0d halted=%b exp 0/0", state, halted); end
    $display("test_hlt done");
  endtask

  task automatic test_reset_mid_swd();
    inst = 16'h8123; #1;
    step(); step();
    mem_ready = 1'b0; #1;
    step();
    checks++; if (state !== 3'd3 || strb !== 7'b0011000) begin failures++; $display("FAIL swd_mem got state=%0d strb=%b exp 3/0011000", state, strb); end
    reset_n = 1'b0; #1;
    step();
    checks++; if (state !== 3'd0 || mem_write !== 1'b0) begin failures++; $display("FAIL swd_reset got state=%0d mem_write=%b exp 0/0", state, mem_write); end
`ifdef CTRL_PERF_CNT_EN
    checks++; if (num_inst !== 16'd0) begin failures++; $display("FAIL perf_reset_inst got=%0d exp=0", num_inst); end
`endif
    reset_n = 1'b1; mem_ready = 1'b1; #1;
    $display("test_reset_mid_swd done");
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    inst = 16'hF1C0; #1;
    step(); step(); step(); step();
    checks++; if (num_inst !== 16'd1 || num_cycle !== 32'd4) begin failures++; $display("FAIL perf_add got inst=%0d cyc=%0d exp 1/4", num_inst, num_cycle); end
    inst = 16'h9005; #1;
    step(); step();
    checks++; if (num_inst !== 16'd2 || num_cycle !== 32'd6) begin failures++; $display("FAIL perf_jmp got inst=%0d cyc=%0d exp 2/6", num_inst, num_cycle); end
    $display("test_perf done");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_func_sweep();
    test_adi_illegal();
    test_lwd_stall();
    test_jmp();
    test_hlt();
    test_reset_mid_swd();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
